// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/response bundle between the fetch stage and the
// instruction memory.
//   req     fetch -> imem   request valid, held until gnt
//   addr    fetch -> imem   word-aligned request address, valid while req=1
//   gnt     imem  -> fetch  request accepted this cycle
//   rvalid  imem  -> fetch  read data valid, at least one cycle after gnt
//   rdata   imem  -> fetch  instruction word
// The fetch unit connects through the master modport and the memory (or a
// testbench memory model) through the slave modport.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Owns the PC, issues one request at a time to the
// instruction memory and drives the pc/inst pair that the IF/ID register
// loads every cycle. IF/ID has no enable, so on stall this block holds its
// own outputs; whenever no real instruction is available it presents a NOP.
//
// Parameters
//   RESET_PC        first PC fetched after reset
//   NOP_INST        bubble encoding (addi x0,x0,0)
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous, active-high reset
//   stall_i         hold pc_next_IFID/inst_next_IFID
//   redirect_i      branch/jump taken: flush and refetch from redirect_pc_i
//   redirect_pc_i   redirect target (bits [1:0] are ignored)
//   imem            instruction-memory bundle (master side)
//   pc_next_IFID    PC presented to IF/ID
//   inst_next_IFID  instruction presented to IF/ID
//   fetch_busy_o    a request has been granted and its data is not back yet
//   perf_fetched_o  count of real instructions delivered
//   perf_bubble_o   count of NOPs presented while not stalled
// Configuration
//   IF_PERF_CNT_EN  when defined, the two perf counters are implemented as
//                   32-bit wrapping counters; otherwise both outputs are 0.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            pc_next_IFID,
    output logic [31:0]            inst_next_IFID,
    output logic                   fetch_busy_o,
    output logic [31:0]            perf_fetched_o,
    output logic [31:0]            perf_bubble_o
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] buf_q, buf_d;
    logic        deliver_w;

    // A request is only offered in FETCH, and never while reset is held so
    // the first request appears in the cycle after reset is released.
    assign imem.req       = (state_q == ST_FETCH) && !rst;
    assign imem.addr      = pc_q;
    assign fetch_busy_o   = (state_q == ST_WAIT) || (state_q == ST_DISCARD);
    assign pc_next_IFID   = pc_out_q;
    assign inst_next_IFID = inst_out_q;

    // A real instruction reaches IF/ID either straight from memory or from
    // the stall buffer, and only when neither a redirect nor a stall blocks it.
    assign deliver_w = !redirect_i && !stall_i &&
                       (((state_q == ST_WAIT) && imem.rvalid) || (state_q == ST_HOLD));

    // State, PC, stall buffer and the IF/ID-facing output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            pc_out_q   <= 32'h0000_0000;
            inst_out_q <= NOP_INST;
            buf_q      <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_out_q   <= pc_out_d;
            inst_out_q <= inst_out_d;
            buf_q      <= buf_d;
        end
    end

    // Next-state logic. Redirect wins over everything, including stall.
    // A response that coincides with a redirect is dropped, and since it
    // also retires the outstanding request there is nothing left to discard.
    // Without a redirect, every non-stalled cycle that does not deliver a
    // real instruction presents a NOP bubble at the current PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_out_d   = pc_out_q;
        inst_out_d = inst_out_q;
        buf_d      = buf_q;

        if (redirect_i) begin
            pc_d       = {redirect_pc_i[31:2], 2'b00};
            pc_out_d   = {redirect_pc_i[31:2], 2'b00};
            inst_out_d = NOP_INST;
            buf_d      = 32'h0000_0000;
            case (state_q)
                ST_FETCH:            state_d = imem.gnt    ? ST_DISCARD : ST_FETCH;
                ST_WAIT, ST_DISCARD: state_d = imem.rvalid ? ST_FETCH   : ST_DISCARD;
                default:             state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem.gnt) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.rvalid) begin
                        if (stall_i) begin
                            buf_d   = imem.rdata;
                            state_d = ST_HOLD;
                        end else begin
                            pc_out_d   = pc_q;
                            inst_out_d = imem.rdata;
                            pc_d       = pc_q + 32'd4;
                            state_d    = ST_FETCH;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        pc_out_d   = pc_q;
                        inst_out_d = buf_q;
                        pc_d       = pc_q + 32'd4;
                        state_d    = ST_FETCH;
                    end
                end
                default: begin
                    if (imem.rvalid) begin
                        state_d = ST_FETCH;
                    end
                end
            endcase

            if (!stall_i && !deliver_w) begin
                pc_out_d   = pc_q;
                inst_out_d = NOP_INST;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] bubble_q;
    logic        bubble_w;

    // Any non-stalled cycle that does not deliver a real instruction puts a
    // NOP into IF/ID, including the flush NOP of a redirect.
    assign bubble_w = !stall_i && !deliver_w;

    // Free-running wrapping performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= 32'h0000_0000;
            bubble_q  <= 32'h0000_0000;
        end else begin
            if (deliver_w) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (bubble_w) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_bubble_o  = bubble_q;
`else
    assign perf_fetched_o = 32'h0000_0000;
    assign perf_bubble_o  = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Drives if_fetch_unit through an instruction-memory model with configurable
// grant and response latency, and compares every cycle against a
// transaction-level reference: a PC, an "outstanding request" flag, a
// "drop the returning word" flag and a one-entry stall buffer.
// Honours IF_PERF_CNT_EN for the expected counter values.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_next_IFID;
    logic [31:0] inst_next_IFID;
    logic        fetch_busy_o;
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_bubble_o;

    if_fetch_unit_if imem ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .stall_i(stall_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem(imem.master),
        .pc_next_IFID(pc_next_IFID),
        .inst_next_IFID(inst_next_IFID),
        .fetch_busy_o(fetch_busy_o),
        .perf_fetched_o(perf_fetched_o),
        .perf_bubble_o(perf_bubble_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state
    logic [31:0] mPc, mOutPc, mOutInst, mBufInst, mFetched, mBubbles;
    bit          mBusy, mDrop, mBufValid;
    // Memory model state (survives DUT reset on purpose)
    bit          memPending = 1'b0;
    int          memCount = 0;
    // Per-cycle expected and observed request-side values
    bit          expReq, expBusy;
    logic [31:0] expAddr;
    logic        obsReq, obsBusy;
    logic [31:0] obsAddr;

    function automatic logic [31:0] expF();
        return PERF ? mFetched : 32'd0;
    endfunction

    function automatic logic [31:0] expB();
        return PERF ? mBubbles : 32'd0;
    endfunction

    task automatic modelReset();
        mPc = 32'h0; mOutPc = 32'h0; mOutInst = NOP; mBufInst = 32'h0;
        mFetched = 32'h0; mBubbles = 32'h0;
        mBusy = 1'b0; mDrop = 1'b0; mBufValid = 1'b0;
    endtask

    // One clock cycle: drive inputs, let the memory answer, sample the
    // request side, then advance the reference on the clock edge.
    task automatic tick(input bit stall, input bit redir, input logic [31:0] rpc,
                        input bit grantOk, input int lat);
        bit accepted, returned, delivered;
        stall_i = stall; redirect_i = redir; redirect_pc_i = rpc;
        expReq  = !mBusy && !mBufValid;
        expAddr = mPc;
        expBusy = mBusy;
        imem.gnt    = grantOk && expReq && !memPending;
        imem.rvalid = 1'b0;
        imem.rdata  = $urandom;
        if (memPending) begin
            memCount--;
            imem.rvalid = (memCount == 0);
        end
        #1;
        obsReq = imem.req; obsAddr = imem.addr; obsBusy = fetch_busy_o;
        @(posedge clk);
        accepted  = imem.gnt;
        returned  = mBusy && imem.rvalid;
        delivered = 1'b0;
        if (imem.rvalid) memPending = 1'b0;
        if (accepted) begin memPending = 1'b1; memCount = lat; end
        if (redir) begin
            mPc = {rpc[31:2], 2'b00};
            mOutPc = mPc; mOutInst = NOP; mBufValid = 1'b0;
            if (returned) begin mBusy = 1'b0; mDrop = 1'b0; end
            else if (mBusy) mDrop = 1'b1;
            else if (accepted) begin mBusy = 1'b1; mDrop = 1'b1; end
        end else begin
            if (returned) begin
                mBusy = 1'b0;
                if (mDrop) mDrop = 1'b0;
                else if (stall) begin mBufValid = 1'b1; mBufInst = imem.rdata; end
                else begin mOutPc = mPc; mOutInst = imem.rdata; mPc = mPc + 32'd4; delivered = 1'b1; end
            end else if (accepted) begin
                mBusy = 1'b1;
            end else if (mBufValid && !stall) begin
                mOutPc = mPc; mOutInst = mBufInst; mPc = mPc + 32'd4; mBufValid = 1'b0; delivered = 1'b1;
            end
            if (!stall && !delivered) begin mOutPc = mPc; mOutInst = NOP; end
        end
        if (delivered) mFetched = mFetched + 32'd1;
        if (!stall && !delivered) mBubbles = mBubbles + 32'd1;
        cyc++;
        #1;
    endtask

    // Let any outstanding or buffered work finish without new grants.
    task automatic drain();
        for (int i = 0; i < 12 && (mBusy || mBufValid || memPending); i++)
            tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
        memPending = 1'b0; memCount = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (imem.req !== 1'b0 || fetch_busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset.req got req=%b busy=%b want 0 0", imem.req, fetch_busy_o);
        end
        checks++;
        if (pc_next_IFID !== 32'h0 || inst_next_IFID !== NOP || perf_fetched_o !== 32'h0 || perf_bubble_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset.out got pc=%h inst=%h perf=%0d/%0d want 0 %h 0/0",
                     pc_next_IFID, inst_next_IFID, perf_fetched_o, perf_bubble_o, NOP);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1, 1);
            checks++;
            if (obsReq !== expReq || obsBusy !== expBusy || (expReq && obsAddr !== expAddr)) begin
                errors++;
                $display("[TB] FAIL basic.req cyc=%0d got req=%b busy=%b addr=%h want req=%b busy=%b addr=%h", cyc, obsReq, obsBusy, obsAddr, expReq, expBusy, expAddr);
            end
            checks++;
            if (pc_next_IFID !== mOutPc || inst_next_IFID !== mOutInst) begin
                errors++;
                $display("[TB] FAIL basic.out cyc=%0d got pc=%h inst=%h want pc=%h inst=%h", cyc, pc_next_IFID, inst_next_IFID, mOutPc, mOutInst);
            end
            checks++;
            if (perf_fetched_o !== expF() || perf_bubble_o !== expB()) begin
                errors++;
                $display("[TB] FAIL basic.perf cyc=%0d got %0d/%0d want %0d/%0d", cyc, perf_fetched_o, perf_bubble_o, expF(), expB());
            end
        end
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h0000_000C) begin
            errors++;
            $display("[TB] FAIL basic.nextaddr got req=%b addr=%h want 1 0000000c", imem.req, imem.addr);
        end
    endtask

    task automatic test_latency();
        drain();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1, 3);
            checks++;
            if (obsReq !== expReq || obsBusy !== expBusy || (expReq && obsAddr !== expAddr)) begin
                errors++;
                $display("[TB] FAIL latency.req cyc=%0d got req=%b busy=%b addr=%h want req=%b busy=%b addr=%h", cyc, obsReq, obsBusy, obsAddr, expReq, expBusy, expAddr);
            end
            checks++;
            if (pc_next_IFID !== mOutPc || inst_next_IFID !== mOutInst) begin
                errors++;
                $display("[TB] FAIL latency.out cyc=%0d got pc=%h inst=%h want pc=%h inst=%h", cyc, pc_next_IFID, inst_next_IFID, mOutPc, mOutInst);
            end
            checks++;
            if (perf_fetched_o !== expF() || perf_bubble_o !== expB()) begin
                errors++;
                $display("[TB] FAIL latency.perf cyc=%0d got %0d/%0d want %0d/%0d", cyc, perf_fetched_o, perf_bubble_o, expF(), expB());
            end
            if (i == 1) begin
                checks++;
                if (obsBusy !== 1'b1 || inst_next_IFID !== NOP) begin
                    errors++;
                    $display("[TB] FAIL latency.wait got busy=%b inst=%h want 1 %h", obsBusy, inst_next_IFID, NOP);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit          stallSeq [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] startPc, bufWord;
        drain();
        startPc = mPc;
        bufWord = 32'h0;
        for (int i = 0; i < 9; i++) begin
            tick(stallSeq[i], 1'b0, 32'h0, 1'b1, 2);
            if (i == 2) bufWord = imem.rdata;
            checks++;
            if (obsReq !== expReq || obsBusy !== expBusy || (expReq && obsAddr !== expAddr)) begin
                errors++;
                $display("[TB] FAIL stall.req cyc=%0d got req=%b busy=%b addr=%h want req=%b busy=%b addr=%h", cyc, obsReq, obsBusy, obsAddr, expReq, expBusy, expAddr);
            end
            checks++;
            if (pc_next_IFID !== mOutPc || inst_next_IFID !== mOutInst) begin
                errors++;
                $display("[TB] FAIL stall.out cyc=%0d got pc=%h inst=%h want pc=%h inst=%h", cyc, pc_next_IFID, inst_next_IFID, mOutPc, mOutInst);
            end
            checks++;
            if (perf_fetched_o !== expF() || perf_bubble_o !== expB()) begin
                errors++;
                $display("[TB] FAIL stall.perf cyc=%0d got %0d/%0d want %0d/%0d", cyc, perf_fetched_o, perf_bubble_o, expF(), expB());
            end
            if (i == 5) begin
                checks++;
                if (pc_next_IFID !== startPc || inst_next_IFID !== bufWord) begin
                    errors++;
                    $display("[TB] FAIL stall.release got pc=%h inst=%h want pc=%h inst=%h", pc_next_IFID, inst_next_IFID, startPc, bufWord);
                end
            end
            if (i == 6) begin
                checks++;
                if (obsReq !== 1'b1 || obsAddr !== startPc + 32'd4) begin
                    errors++;
                    $display("[TB] FAIL stall.nextaddr got req=%b addr=%h want 1 %h", obsReq, obsAddr, startPc + 32'd4);
                end
            end
        end
    endtask

    task automatic test_redirect();
        drain();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, (i == 2), 32'h0000_0100, 1'b1, 3);
            checks++;
            if (obsReq !== expReq || obsBusy !== expBusy || (expReq && obsAddr !== expAddr)) begin
                errors++;
                $display("[TB] FAIL redirect.req cyc=%0d got req=%b busy=%b addr=%h want req=%b busy=%b addr=%h", cyc, obsReq, obsBusy, obsAddr, expReq, expBusy, expAddr);
            end
            checks++;
            if (pc_next_IFID !== mOutPc || inst_next_IFID !== mOutInst) begin
                errors++;
                $display("[TB] FAIL redirect.out cyc=%0d got pc=%h inst=%h want pc=%h inst=%h", cyc, pc_next_IFID, inst_next_IFID, mOutPc, mOutInst);
            end
            checks++;
            if (perf_fetched_o !== expF() || perf_bubble_o !== expB()) begin
                errors++;
                $display("[TB] FAIL redirect.perf cyc=%0d got %0d/%0d want %0d/%0d", cyc, perf_fetched_o, perf_bubble_o, expF(), expB());
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (pc_next_IFID !== 32'h0000_0100 || inst_next_IFID !== NOP) begin
                    errors++;
                    $display("[TB] FAIL redirect.flush step=%0d got pc=%h inst=%h want 00000100 %h", i, pc_next_IFID, inst_next_IFID, NOP);
                end
            end
            if (i == 4) begin
                checks++;
                if (obsReq !== 1'b1 || obsAddr !== 32'h0000_0100) begin
                    errors++;
                    $display("[TB] FAIL redirect.refetch got req=%b addr=%h want 1 00000100", obsReq, obsAddr);
                end
            end
        end
    endtask

    task automatic test_wrap();
        bit          redirSeq [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bit          grantSeq [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] pcSeq    [5] = '{32'h0000_0203, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0};
        drain();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, redirSeq[i], pcSeq[i], grantSeq[i], 1);
            checks++;
            if (obsReq !== expReq || obsBusy !== expBusy || (expReq && obsAddr !== expAddr)) begin
                errors++;
                $display("[TB] FAIL wrap.req cyc=%0d got req=%b busy=%b addr=%h want req=%b busy=%b addr=%h", cyc, obsReq, obsBusy, obsAddr, expReq, expBusy, expAddr);
            end
            checks++;
            if (pc_next_IFID !== mOutPc || inst_next_IFID !== mOutInst) begin
                errors++;
                $display("[TB] FAIL wrap.out cyc=%0d got pc=%h inst=%h want pc=%h inst=%h", cyc, pc_next_IFID, inst_next_IFID, mOutPc, mOutInst);
            end
            if (i == 0) begin
                checks++;
                if (pc_next_IFID !== 32'h0000_0200) begin
                    errors++;
                    $display("[TB] FAIL wrap.align got pc=%h want 00000200", pc_next_IFID);
                end
            end
            if (i == 3) begin
                checks++;
                if (pc_next_IFID !== 32'hFFFF_FFFC) begin
                    errors++;
                    $display("[TB] FAIL wrap.last got pc=%h want fffffffc", pc_next_IFID);
                end
            end
            if (i == 4) begin
                checks++;
                if (obsReq !== 1'b1 || obsAddr !== 32'h0000_0000) begin
                    errors++;
                    $display("[TB] FAIL wrap.zero got req=%b addr=%h want 1 00000000", obsReq, obsAddr);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        drain();
        tick(1'b0, 1'b0, 32'h0, 1'b1, 3);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 3);
        rst = 1'b1;
        #1;
        checks++;
        if (imem.req !== 1'b0 || fetch_busy_o !== 1'b0 || pc_next_IFID !== 32'h0 || inst_next_IFID !== NOP) begin
            errors++;
            $display("[TB] FAIL midreset.async got req=%b busy=%b pc=%h inst=%h want 0 0 00000000 %h", imem.req, fetch_busy_o, pc_next_IFID, inst_next_IFID, NOP);
        end
        rst = 1'b0;
        modelReset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1, 1);
            checks++;
            if (obsReq !== expReq || obsBusy !== expBusy || (expReq && obsAddr !== expAddr)) begin
                errors++;
                $display("[TB] FAIL midreset.req cyc=%0d got req=%b busy=%b addr=%h want req=%b busy=%b addr=%h", cyc, obsReq, obsBusy, obsAddr, expReq, expBusy, expAddr);
            end
            checks++;
            if (pc_next_IFID !== mOutPc || inst_next_IFID !== mOutInst) begin
                errors++;
                $display("[TB] FAIL midreset.out cyc=%0d got pc=%h inst=%h want pc=%h inst=%h", cyc, pc_next_IFID, inst_next_IFID, mOutPc, mOutInst);
            end
        end
    endtask

    task automatic test_perf();
        drain();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        modelReset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1, 1);
            checks++;
            if (perf_fetched_o !== expF() || perf_bubble_o !== expB()) begin
                errors++;
                $display("[TB] FAIL perf.step cyc=%0d got %0d/%0d want %0d/%0d", cyc, perf_fetched_o, perf_bubble_o, expF(), expB());
            end
        end
        checks++;
        if (perf_fetched_o !== (PERF ? 32'd10 : 32'd0) || perf_bubble_o !== (PERF ? 32'd10 : 32'd0)) begin
            errors++;
            $display("[TB] FAIL perf.total got %0d/%0d want %0d/%0d", perf_fetched_o, perf_bubble_o, PERF ? 10 : 0, PERF ? 10 : 0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), $urandom,
                 ($urandom_range(0, 2) != 0), $urandom_range(1, 4));
            checks++;
            if (obsReq !== expReq || obsBusy !== expBusy || (expReq && obsAddr !== expAddr)) begin
                errors++;
                $display("[TB] FAIL random.req cyc=%0d got req=%b busy=%b addr=%h want req=%b busy=%b addr=%h", cyc, obsReq, obsBusy, obsAddr, expReq, expBusy, expAddr);
            end
            checks++;
            if (pc_next_IFID !== mOutPc || inst_next_IFID !== mOutInst) begin
                errors++;
                $display("[TB] FAIL random.out cyc=%0d got pc=%h inst=%h want pc=%h inst=%h", cyc, pc_next_IFID, inst_next_IFID, mOutPc, mOutInst);
            end
            checks++;
            if (perf_fetched_o !== expF() || perf_bubble_o !== expB()) begin
                errors++;
                $display("[TB] FAIL random.perf cyc=%0d got %0d/%0d want %0d/%0d", cyc, perf_fetched_o, perf_bubble_o, expF(), expB());
            end
        end
    endtask

    initial begin
        $display("[TB] if_fetch_unit bench start (perf counters %0s)", PERF ? "on" : "off");
        test_reset();
        test_basic();
        test_latency();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_midflight();
        test_perf();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
